// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: cache geometry,
// reset PC, FSM state encoding and PC index/tag split helpers.
package if_stage_pkg;

    localparam int          ICACHE_ENTRIES = 64;
    localparam int          INDEX_W        = $clog2(ICACHE_ENTRIES);
    localparam int          TAG_W          = 32 - 2 - INDEX_W;
    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] ZERO32         = 32'h0000_0000;

    // LOOKUP: probing the cache with the current pc.
    // FETCH : a miss is outstanding at the memory controller.
    typedef enum logic {
        LOOKUP = 1'b0,
        FETCH  = 1'b1
    } if_state_e;

    function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[INDEX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:INDEX_W+2];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, memory-controller and IF/ID signals.
//
// Handshake rules:
//   - memReq_out is a level request; once raised it stays high with a stable
//     memAddr_out until the controller answers with a one-cycle memInstE_in
//     pulse (memInst_in valid in that cycle). Dropping memReq_out without a
//     pulse abandons the transfer.
//   - idValid_out qualifies idPC_out/idInst_out. stall_in acts as the inverse
//     of ID's ready: while it is high the IF/ID outputs are held unchanged.
interface if_stage_if;
    logic        stall_in;
    logic        jump_in;
    logic [31:0] jumpAddr_in;
    logic        memInstE_in;
    logic [31:0] memInst_in;
    logic        memReq_out;
    logic [31:0] memAddr_out;
    logic        idValid_out;
    logic [31:0] idPC_out;
    logic [31:0] idInst_out;
    logic        ifStall_out;

    // The fetch stage itself.
    modport master (
        input  stall_in, jump_in, jumpAddr_in, memInstE_in, memInst_in,
        output memReq_out, memAddr_out, idValid_out, idPC_out, idInst_out,
        ifStall_out
    );

    // The surrounding pipeline / memory controller.
    modport slave (
        output stall_in, jump_in, jumpAddr_in, memInstE_in, memInst_in,
        input  memReq_out, memAddr_out, idValid_out, idPC_out, idInst_out,
        ifStall_out
    );
endinterface

// File: rtl/if_stage_icache.sv
// Direct-mapped, one-word-per-line instruction cache. Combinational lookup,
// synchronous fill, valid bits cleared asynchronously by reset.
module if_stage_icache
    import if_stage_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [INDEX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    output logic [31:0]        rd_data,
    input  logic               fill_en,
    input  logic [31:0]        fill_data
);

    logic [ICACHE_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]          tag_q  [ICACHE_ENTRIES];
    logic [31:0]               data_q [ICACHE_ENTRIES];

    // Valid bits: cleared by reset, set on fill of the addressed line.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[lookup_idx] <= 1'b1;
        end
    end

    // Tag/data storage; contents of invalid lines are don't-care.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[lookup_idx]  <= lookup_tag;
            data_q[lookup_idx] <= fill_data;
        end
    end

    assign hit     = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign rd_data = data_q[lookup_idx];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the pc, looks it up in the icache, fetches
// misses from the memory controller and feeds the IF/ID latch. Redirect has
// priority over stall, which has priority over normal fetch.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    if_stage_if.master  bus,
    output if_state_e   state_dbg_out,
    output logic [31:0] pc_dbg_out
);

    if_state_e          state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               req_d;
    logic [31:0]        addr_d;
    logic               idv_d;
    logic [31:0]        idpc_d, idinst_d;
    logic               ifstall_d;
    logic               fill_en;
    logic               hit;
    logic [31:0]        hit_data;
    logic [INDEX_W-1:0] pc_idx;
    logic [TAG_W-1:0]   pc_tg;

    assign pc_idx = pc_index(pc_q);
    assign pc_tg  = pc_tag(pc_q);

    if_stage_icache u_icache (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .lookup_idx (pc_idx),
        .lookup_tag (pc_tg),
        .hit        (hit),
        .rd_data    (hit_data),
        .fill_en    (fill_en),
        .fill_data  (bus.memInst_in)
    );

    // State, pc and all registered outputs; reset drops the request at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= LOOKUP;
            pc_q            <= RESET_PC;
            bus.memReq_out  <= 1'b0;
            bus.memAddr_out <= ZERO32;
            bus.idValid_out <= 1'b0;
            bus.idPC_out    <= ZERO32;
            bus.idInst_out  <= ZERO32;
            bus.ifStall_out <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            bus.memReq_out  <= req_d;
            bus.memAddr_out <= addr_d;
            bus.idValid_out <= idv_d;
            bus.idPC_out    <= idpc_d;
            bus.idInst_out  <= idinst_d;
            bus.ifStall_out <= ifstall_d;
        end
    end

    // Next-state and next-output decode: jump > stall > lookup/fetch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = bus.memReq_out;
        addr_d    = bus.memAddr_out;
        idv_d     = bus.idValid_out;
        idpc_d    = bus.idPC_out;
        idinst_d  = bus.idInst_out;
        ifstall_d = bus.ifStall_out;
        fill_en   = 1'b0;

        if (bus.jump_in) begin
            // Abandon any outstanding miss; its fill is never written.
            pc_d      = bus.jumpAddr_in;
            state_d   = LOOKUP;
            req_d     = 1'b0;
            ifstall_d = 1'b0;
            idv_d     = 1'b0;
        end else begin
            unique case (state_q)
                LOOKUP: begin
                    if (!bus.stall_in) begin
                        if (hit) begin
                            idv_d    = 1'b1;
                            idpc_d   = pc_q;
                            idinst_d = hit_data;
                            pc_d     = pc_q + 32'd4;
                        end else begin
                            idv_d     = 1'b0;
                            req_d     = 1'b1;
                            addr_d    = pc_q;
                            ifstall_d = 1'b1;
                            state_d   = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (!bus.stall_in) begin
                        idv_d = 1'b0;
                    end
                    if (bus.memInstE_in) begin
                        // Drop the request on the same edge so the
                        // controller does not start another transfer.
                        fill_en   = 1'b1;
                        req_d     = 1'b0;
                        ifstall_d = 1'b0;
                        state_d   = LOOKUP;
                    end
                end
                default: state_d = LOOKUP;
            endcase
        end
    end

    assign state_dbg_out = state_q;
    assign pc_dbg_out    = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed walk through cold start, hot loop, stall,
// redirect, aliasing and async reset, then randomized traffic. A per-cycle
// behavioural model (address-keyed cache, pc, pending-miss flag) predicts
// every output; a small memory-controller model answers requests.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  if_state_e   state_dbg;
  logic [31:0] pc_dbg;

  if_stage_if bus ();

  if_stage dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bus           (bus),
    .state_dbg_out (state_dbg),
    .pc_dbg_out    (pc_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_wait;
  logic [31:0] m_addr;
  bit          m_idv;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  logic [31:0] line_addr [int];
  logic [31:0] line_data [int];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_wait   = 1'b0;
    m_addr   = 32'h0;
    m_idv    = 1'b0;
    m_idpc   = 32'h0;
    m_idinst = 32'h0;
    line_addr.delete();
    line_data.delete();
  endtask

  task automatic model_step(input bit stall, input bit jump, input logic [31:0] jaddr,
                            input bit mem_e, input logic [31:0] mem_d);
    int idx;
    idx = int'((m_pc / 4) % ICACHE_ENTRIES);
    if (jump) begin
      m_pc   = jaddr;
      m_wait = 1'b0;
      m_idv  = 1'b0;
    end else if (!m_wait) begin
      if (!stall) begin
        if (line_addr.exists(idx) && line_addr[idx] == m_pc) begin
          m_idv    = 1'b1;
          m_idpc   = m_pc;
          m_idinst = line_data[idx];
          m_pc     = m_pc + 32'd4;
        end else begin
          m_idv  = 1'b0;
          m_addr = m_pc;
          m_wait = 1'b1;
        end
      end
    end else begin
      if (!stall) m_idv = 1'b0;
      if (mem_e) begin
        line_addr[idx] = m_pc;
        line_data[idx] = mem_d;
        m_wait         = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("memReq",  32'(bus.memReq_out),  32'(m_wait));
    check("memAddr", bus.memAddr_out,      m_addr);
    check("ifStall", 32'(bus.ifStall_out), 32'(m_wait));
    check("idValid", 32'(bus.idValid_out), 32'(m_idv));
    check("idPC",    bus.idPC_out,         m_idpc);
    check("idInst",  bus.idInst_out,       m_idinst);
    check("pc",      pc_dbg,               m_pc);
    check("state",   32'(state_dbg),       m_wait ? 32'(FETCH) : 32'(LOOKUP));
  endtask

  // ---------------- driver + memory controller model ----------------
  int lat         = 5;
  int cnt         = 0;
  bit force_pulse = 1'b0;
  bit stale_en    = 1'b0;

  // Drive one cycle of inputs at a negedge, advance the model, then compare
  // at the following negedge.
  task automatic cycle(input bit stall, input bit jump, input logic [31:0] jaddr);
    bit          e;
    logic [31:0] d;
    e = 1'b0;
    d = 32'h0;
    if (bus.memReq_out) begin
      cnt++;
      if (cnt >= lat) begin
        e   = 1'b1;
        d   = mem_word(bus.memAddr_out);
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
    if (!e && (force_pulse || (stale_en && !bus.memReq_out && $urandom_range(0, 15) == 0))) begin
      e = 1'b1;
      d = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
    end
    bus.stall_in    = stall;
    bus.jump_in     = jump;
    bus.jumpAddr_in = jaddr;
    bus.memInstE_in = e;
    bus.memInst_in  = d;
    model_step(stall, jump, jaddr, e, d);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic wait_deliver(input logic [31:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (m_idv && m_idpc == a) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.stall_in    = 1'b0;
    bus.jump_in     = 1'b0;
    bus.jumpAddr_in = 32'h0;
    bus.memInstE_in = 1'b0;
    bus.memInst_in  = 32'h0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_all();
    rst_in = 1'b1;

    // Cold start
    lat = 5;
    cycle(1'b0, 1'b0, 32'h0);
    check("cold_req",    32'(bus.memReq_out),  32'd1);
    check("cold_addr",   bus.memAddr_out,      32'h0);
    check("cold_ifstall", 32'(bus.ifStall_out), 32'd1);
    wait_deliver(32'h0, "cold_deliver");
    check("cold_inst", bus.idInst_out, 32'h0000_0013);
    check("cold_pc",   pc_dbg,         32'h4);
    wait_deliver(32'h4, "warm_4");
    wait_deliver(32'h8, "warm_8");

    // Hot loop over cached 0,4,8
    cycle(1'b0, 1'b1, 32'h0);
    check("hot_jump_idv", 32'(bus.idValid_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      check("hot_pc",    bus.idPC_out,          32'(i * 4));
      check("hot_idv",   32'(bus.idValid_out),  32'd1);
      check("hot_noreq", 32'(bus.memReq_out),   32'd0);
    end

    // Stall while pc=8 is on the IF/ID outputs
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("stall_idpc", bus.idPC_out,         32'h8);
      check("stall_idv",  32'(bus.idValid_out), 32'd1);
      check("stall_pc",   pc_dbg,               32'hC);
    end
    wait_deliver(32'hC, "stall_resume");

    // Redirect mid-miss, followed by a stale pulse
    lat = 1000;
    cycle(1'b0, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    check("redir_req",  32'(bus.memReq_out), 32'd1);
    check("redir_addr", bus.memAddr_out,     32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h200);
    check("redir_drop", 32'(bus.memReq_out), 32'd0);
    force_pulse = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    force_pulse = 1'b0;
    check("redir_newreq",  32'(bus.memReq_out), 32'd1);
    check("redir_newaddr", bus.memAddr_out,     32'h200);
    lat = 4;
    wait_deliver(32'h200, "redir_deliver");
    cycle(1'b0, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    check("redir_line_invalid", 32'(bus.memReq_out), 32'd1);

    // Aliasing: 0x100 evicts 0x0 from line 0
    wait_deliver(32'h100, "alias_fill");
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("alias_refetch_req",  32'(bus.memReq_out), 32'd1);
    check("alias_refetch_addr", bus.memAddr_out,     32'h0);

    // Async reset while a miss is outstanding
    lat = 1000;
    cycle(1'b0, 1'b0, 32'h0);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_req",   32'(bus.memReq_out),  32'd0);
    check("arst_idv",   32'(bus.idValid_out), 32'd0);
    check("arst_state", 32'(state_dbg),       32'(LOOKUP));
    model_reset();
    @(negedge clk_in);
    check_all();
    rst_in = 1'b1;
    lat    = 3;
    cycle(1'b0, 1'b0, 32'h0);
    check("arst_restart_req",  32'(bus.memReq_out), 32'd1);
    check("arst_restart_addr", bus.memAddr_out,     RESET_PC);
    wait_deliver(RESET_PC, "arst_deliver");
    cycle(1'b0, 1'b1, 32'h4);
    cycle(1'b0, 1'b0, 32'h0);
    check("arst_lines_invalid", 32'(bus.memReq_out), 32'd1);

    // Randomized traffic, including pc wrap near 32'hFFFFFFFC
    stale_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      bit          st, jp;
      logic [31:0] ja;
      if (!bus.memReq_out) lat = $urandom_range(1, 6);
      st = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) ja = 32'hFFFF_FFF8;
      else                            ja = 32'($urandom_range(0, 255)) << 2;
      cycle(st, jp, ja);
    end
    stale_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. Holds the PC and looks it up in a small direct-mapped instruction cache.
- On a miss it requests a 4-byte instruction from the memory controller (IF request port) and fills the cache.
- Delivers {pc, instruction} to the IF/ID latch, honouring pipeline stall and branch/jump redirect.

Parameters:
- ICACHE_ENTRIES, 64, number of one-word cache lines (power of 2).
- INDEX_W, 6, log2(ICACHE_ENTRIES); index = pc[INDEX_W+1:2].
- TAG_W, 24, 32-2-INDEX_W; tag = pc[31:INDEX_W+2].
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  asynchronous, active-low reset.
- stall_in  input  1  1 = ID cannot accept; hold PC and ID outputs.
- jump_in  input  1  1 = redirect fetch this cycle.
- jumpAddr_in  input  32  redirect target (word aligned).
- memInstE_in  input  1  memory controller instruction-valid pulse.
- memInst_in  input  32  instruction from memory controller (little-endian assembled).
- memReq_out  output  1  IF request to memory controller (held until memInstE_in).
- memAddr_out  output  32  fetch address to memory controller.
- idValid_out  output  1  IF/ID entry valid.
- idPC_out  output  32  PC of delivered instruction.
- idInst_out  output  32  delivered instruction.
- ifStall_out  output  1  1 while a miss is outstanding (to stall controller).

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC; state=LOOKUP; all valid bits=0; memReq_out=0; memAddr_out=0; idValid_out=0; idPC_out=0; idInst_out=0; ifStall_out=0. Reset mid-fetch drops memReq_out immediately, which aborts the controller transfer.
- Cache: valid[ICACHE_ENTRIES], tag[], data[]. hit = valid[idx] && tag[idx]==pc tag, evaluated combinationally on the current pc.
- Priority each cycle: jump_in > stall_in > normal operation.
- jump_in=1 (any state):
  - pc<=jumpAddr_in; state<=LOOKUP; memReq_out<=0; ifStall_out<=0; idValid_out<=0.
  - Outstanding miss is abandoned: dropping the request resets the controller counter.
  - No cache write for the abandoned fetch.
- LOOKUP, no jump:
  - stall_in=1: pc, id outputs and state all hold.
  - stall_in=0 and hit: idValid_out<=1, idPC_out<=pc, idInst_out<=data[idx], pc<=pc+4 (mod 2^32, wraps at 32'hFFFFFFFC).
  - stall_in=0 and miss: idValid_out<=0; memReq_out<=1; memAddr_out<=pc; ifStall_out<=1; state<=FETCH.
  - A hit with stall_in=0 delivers one instruction per cycle.
- FETCH, no jump:
  - memReq_out and memAddr_out are held stable. The controller may serve MEM first; waiting is unbounded.
  - Stall handling: if stall_in=1 the id outputs hold; otherwise idValid_out<=0.
  - On memInstE_in=1:
    - Fill: valid[idx]<=1, tag[idx]<=pc tag, data[idx]<=memInst_in.
    - memReq_out<=0 in that same edge, so the controller sees tot=0 next cycle and does not restart.
    - ifStall_out<=0; state<=LOOKUP. The next cycle hits and delivers.
  - Miss-to-delivery latency = controller latency + 2 cycles.
- memInstE_in while in LOOKUP (stale pulse after a jump) is ignored; no cache write.
- jump_in and memInstE_in on the same cycle: jump wins and the fill is discarded.
- Write-through from MEM is not tracked (no self-modifying code support); no flush port.

Decomposition:
- Shared defines header (existing defines.vh): instRange, addrRange, Enable/Disable, ZERO32, plus new ICACHE_ENTRIES/INDEX_W/TAG_W defaults and the LOOKUP/FETCH state encodings.
- One sub-module is natural: icache (valid/tag/data arrays, combinational hit/read, synchronous fill, async clear of valid bits).

Test Plan:
- Cold start: reset release with RESET_PC=0, controller model returns 32'h00000013 after 5 cycles → memReq_out=1, memAddr_out=0, ifStall_out=1; memReq_out falls with memInstE_in; 2 cycles later idValid_out=1, idPC_out=0, idInst_out=32'h00000013; pc=4.
- Hot loop: jump_in to 32'h00000000 after addresses 0,4,8 are cached → three consecutive cycles deliver PCs 0,4,8 with no memReq_out.
- Stall: assert stall_in for 3 cycles during hit delivery at pc=8 → idPC_out stays 8, idValid_out stays 1, pc does not advance; resumes with 12.
- Redirect mid-miss: in FETCH for 32'h100, assert jump_in with jumpAddr_in=32'h200 one cycle before memInstE_in → memReq_out=0 next cycle; stale pulse ignored; cache line for 32'h100 remains invalid; new request issued for 32'h200.
- Conflict/aliasing: fetch 32'h0, then 32'h100 (same index, tag differs) → second access misses and refills; re-fetch of 32'h0 misses again.
- Async reset during FETCH: drop rst_in mid-cycle → memReq_out=0 and idValid_out=0 immediately without a clock edge; after release, fetch restarts at RESET_PC with all lines invalid.
